// File: rtl/rl_fifo_1r1w_ctrl.sv
// First-word-fall-through FIFO controller in front of a 1R1W RAM with registered read data.
// Latency: a push into an empty FIFO becomes visible on rdata_o/empty_o three edges later.
// Backpressure: full_o blocks pushes once the RAM region holds 2^ABITS words; pops are refused while empty_o is high.
module rl_fifo_1r1w_ctrl #(
  parameter int ABITS = 10,
  parameter int DBITS = 32,
  localparam int BEBITS = (DBITS + 7) / 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DBITS-1:0]  wdata_i,
  output logic              full_o,
  input  logic              pop_i,
  output logic [DBITS-1:0]  rdata_o,
  output logic              empty_o,
  output logic              ovf_o,
  output logic              udf_o,
  output logic [ABITS-1:0]  ram_waddr_o,
  output logic [DBITS-1:0]  ram_din_o,
  output logic              ram_we_o,
  output logic [BEBITS-1:0] ram_be_o,
  output logic [ABITS-1:0]  ram_raddr_o,
  input  logic [DBITS-1:0]  ram_dout_i
);

  // One extra pointer bit distinguishes a full RAM region from an empty one.
  localparam logic [ABITS:0] RAM_WORDS = {1'b1, {ABITS{1'b0}}};

  logic [ABITS:0]   wr_ptr_q, wr_ptr_d;
  logic [ABITS:0]   rd_ptr_q, rd_ptr_d;
  logic             rd_pend_q, rd_pend_d;
  logic             head_vld_q, head_vld_d;
  logic [DBITS-1:0] head_dat_q, head_dat_d;
  logic             skid_vld_q, skid_vld_d;
  logic [DBITS-1:0] skid_dat_q, skid_dat_d;

  logic [ABITS:0]   ram_cnt;
  logic             ram_full;
  logic             push_acc;
  logic             pop_acc;
  logic [1:0]       occ;
  logic [1:0]       occ_next;
  logic             iss;

  // Occupancy, accept and read-issue decisions, all from registered state plus this cycle's requests.
  always_comb begin
    ram_cnt  = wr_ptr_q - rd_ptr_q;
    ram_full = (ram_cnt == RAM_WORDS);
    push_acc = push_i & ~ram_full;
    pop_acc  = pop_i & head_vld_q;
    occ      = {1'b0, head_vld_q} + {1'b0, skid_vld_q};
    // Entries the output stage will have to hold once any in-flight read lands;
    // a new read may only be issued if there is still a slot left for it.
    occ_next = occ + {1'b0, rd_pend_q} - {1'b0, pop_acc};
    iss      = (ram_cnt != '0) & (occ_next < 2'd2);
  end

  // Next-state for pointers and the head/skid output stage.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + {{ABITS{1'b0}}, push_acc};
    rd_ptr_d   = rd_ptr_q + {{ABITS{1'b0}}, iss};
    rd_pend_d  = iss;
    head_vld_d = head_vld_q;
    head_dat_d = head_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;

    // A pop advances the skid word into the head slot.
    if (pop_acc) begin
      head_vld_d = skid_vld_q;
      if (skid_vld_q) begin
        head_dat_d = skid_dat_q;
      end
      skid_vld_d = 1'b0;
    end

    // Returning RAM data fills whichever slot is free after the pop, head first,
    // so ordering is preserved.
    if (rd_pend_q) begin
      if (!head_vld_d) begin
        head_vld_d = 1'b1;
        head_dat_d = ram_dout_i;
      end else begin
        skid_vld_d = 1'b1;
        skid_dat_d = ram_dout_i;
      end
    end
  end

  // State registers; reset drops all contents but leaves the RAM untouched.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_pend_q  <= 1'b0;
      head_vld_q <= 1'b0;
      head_dat_q <= '0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_pend_q  <= rd_pend_d;
      head_vld_q <= head_vld_d;
      head_dat_q <= head_dat_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
    end
  end

  // Outputs; strobes are held off while reset is asserted so no stray RAM write slips through.
  always_comb begin
    full_o      = ram_full;
    empty_o     = ~head_vld_q;
    rdata_o     = head_dat_q;
    ovf_o       = push_i & ram_full & rst_ni;
    udf_o       = pop_i & ~head_vld_q & rst_ni;
    ram_we_o    = push_acc & rst_ni;
    ram_waddr_o = wr_ptr_q[ABITS-1:0];
    ram_din_o   = wdata_i;
    ram_be_o    = '1;
    ram_raddr_o = rd_ptr_q[ABITS-1:0];
  end

endmodule

// File: tb/tb_rl_fifo_1r1w_ctrl.sv
// Directed bench for rl_fifo_1r1w_ctrl with ABITS=2 and a behavioural 1R1W RAM.
// Inputs change on the falling edge; state is sampled 1 ns after the rising edge.
// Pass/fail summary printed at the end.
module tb_rl_fifo_1r1w_ctrl;

  localparam int ABITS = 2;
  localparam int DBITS = 32;
  localparam int CAP   = (1 << ABITS) + 2;

  logic              clk;
  logic              rst_n;
  logic              push;
  logic [DBITS-1:0]  wdata;
  logic              full;
  logic              pop;
  logic [DBITS-1:0]  rdata;
  logic              empty;
  logic              ovf;
  logic              udf;
  logic [ABITS-1:0]  ram_waddr;
  logic [DBITS-1:0]  ram_din;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [ABITS-1:0]  ram_raddr;
  logic [DBITS-1:0]  ram_dout;

  logic [DBITS-1:0]  mem [1 << ABITS];

  logic              ovf_s, udf_s, we_s;
  int                n_chk = 0;
  int                n_bad = 0;
  logic [DBITS-1:0]  sb [$];

  rl_fifo_1r1w_ctrl #(.ABITS(ABITS), .DBITS(DBITS)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .push_i      (push),
    .wdata_i     (wdata),
    .full_o      (full),
    .pop_i       (pop),
    .rdata_o     (rdata),
    .empty_o     (empty),
    .ovf_o       (ovf),
    .udf_o       (udf),
    .ram_waddr_o (ram_waddr),
    .ram_din_o   (ram_din),
    .ram_we_o    (ram_we),
    .ram_be_o    (ram_be),
    .ram_raddr_o (ram_raddr),
    .ram_dout_i  (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM with one-cycle registered read.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_din;
    ram_dout <= mem[ram_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: drive on the falling edge, capture the strobes, then step past the rising edge.
  task automatic cyc(input logic p, input logic [31:0] d, input logic q);
    @(negedge clk);
    push  = p;
    wdata = d;
    pop   = q;
    #1;
    ovf_s = ovf;
    udf_s = udf;
    we_s  = ram_we;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    int pushed;
    int popped;
    int cycles;
    logic p;
    logic q;

    rst_n = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    wdata = '0;
    ovf_s = 1'b0;
    udf_s = 1'b0;
    we_s  = 1'b0;

    // Reset values
    #12;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_udf", udf, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_be", ram_be, 4'hf);
    @(negedge clk);
    rst_n = 1'b1;

    // Push-to-visible latency: push at E0, empty drops only after E2
    cyc(1'b1, 32'hA5, 1'b0);
    chk("lat_we", we_s, 1);
    chk("lat_e0", empty, 1);
    idle(1);
    chk("lat_e1", empty, 1);
    idle(1);
    chk("lat_e2", empty, 0);
    chk("lat_dat", rdata, 32'hA5);
    cyc(1'b0, 32'h0, 1'b1);
    chk("lat_pop_udf", udf_s, 0);
    chk("lat_pop_empty", empty, 1);

    // Asynchronous reset in the middle of a stream, with a push held on the input
    cyc(1'b1, 32'h31, 1'b0);
    cyc(1'b1, 32'h32, 1'b0);
    cyc(1'b1, 32'h33, 1'b0);
    idle(2);
    chk("mid_pre_empty", empty, 0);
    push  = 1'b1;
    wdata = 32'h34;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_we", ram_we, 0);
    @(negedge clk);
    push  = 1'b0;
    rst_n = 1'b1;
    cyc(1'b1, 32'h77, 1'b0);
    idle(1);
    chk("post_rst_e1", empty, 1);
    idle(1);
    chk("post_rst_e2", empty, 0);
    chk("post_rst_dat", rdata, 32'h77);
    cyc(1'b0, 32'h0, 1'b1);
    idle(2);
    chk("post_rst_drained", empty, 1);

    // Fill: 2 words land in the output stage, 4 in the RAM region
    for (int i = 0; i < CAP; i++) begin
      chk("fill_full_before", full, 0);
      cyc(1'b1, 32'h10 + i, 1'b0);
      chk("fill_we", we_s, 1);
      chk("fill_ovf", ovf_s, 0);
    end
    chk("fill_full", full, 1);
    cyc(1'b1, 32'h99, 1'b0);
    chk("fill_ovf_pulse", ovf_s, 1);
    chk("fill_rej_we", we_s, 0);
    chk("fill_rej_full", full, 1);
    chk("fill_rej_head", rdata, 32'h10);
    idle(1);
    chk("fill_ovf_clear", ovf, 0);

    // Push while full together with a pop: push refused, pop taken, full drops next cycle
    cyc(1'b1, 32'h99, 1'b1);
    chk("fp_ovf", ovf_s, 1);
    chk("fp_udf", udf_s, 0);
    chk("fp_we", we_s, 0);
    chk("fp_full_drop", full, 0);
    chk("fp_head", rdata, 32'h11);

    // Drain the remaining five words back to back
    for (int i = 1; i < CAP; i++) begin
      chk("drain_empty", empty, 0);
      chk("drain_dat", rdata, 32'h10 + i);
      cyc(1'b0, 32'h0, 1'b1);
      chk("drain_udf", udf_s, 0);
    end
    chk("drain_done", empty, 1);
    cyc(1'b0, 32'h0, 1'b1);
    chk("drain_udf_pulse", udf_s, 1);
    chk("drain_still_empty", empty, 1);

    // Streaming: two words in the output stage plus one behind them in the RAM,
    // then push and pop every cycle; head must stay valid throughout.
    for (int i = 0; i < 3; i++) begin
      sb.push_back(32'h100 + i);
      cyc(1'b1, 32'h100 + i, 1'b0);
    end
    idle(4);
    for (int i = 0; i < 100; i++) begin
      chk("strm_bubble", empty, 0);
      if (sb.size() > 0) chk("strm_dat", rdata, sb.pop_front());
      sb.push_back(32'h103 + i);
      cyc(1'b1, 32'h103 + i, 1'b1);
      if (ovf_s || udf_s) chk("strm_flags", {30'b0, ovf_s, udf_s}, 0);
    end
    for (int k = 0; k < 12 && sb.size() > 0; k++) begin
      if (!empty) begin
        chk("strm_tail_dat", rdata, sb.pop_front());
        cyc(1'b0, 32'h0, 1'b1);
      end else begin
        idle(1);
      end
    end
    chk("strm_left", sb.size(), 0);
    chk("strm_empty", empty, 1);

    // Wrap: 3*CAP words with random gaps, scoreboarded
    pushed = 0;
    popped = 0;
    cycles = 0;
    while ((pushed < 3 * CAP || popped < 3 * CAP) && cycles < 2000) begin
      p = (pushed < 3 * CAP) && !full && ($urandom_range(0, 1) == 1);
      q = !empty && ($urandom_range(0, 2) != 0);
      if (q) begin
        if (sb.size() == 0) begin
          chk("wrap_extra", 1, 0);
        end else begin
          chk("wrap_dat", rdata, sb.pop_front());
        end
        popped++;
      end
      if (p) begin
        sb.push_back(32'h200 + pushed);
      end
      cyc(p, 32'h200 + pushed, q);
      if (p) pushed++;
      if (ovf_s || udf_s) chk("wrap_flags", {30'b0, ovf_s, udf_s}, 0);
      cycles++;
    end
    chk("wrap_pushed", pushed, 3 * CAP);
    chk("wrap_popped", popped, 3 * CAP);
    chk("wrap_empty", empty, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
